// File: rtl/y86_pkg.sv
// Shared Y86 definitions: icode values, memory-initiator FSM states, operand selects.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Address comes from valE unless the stack is being popped through valA.
  localparam logic ADDR_SEL_VALE = 1'b0;
  localparam logic ADDR_SEL_VALA = 1'b1;

  // Write data is valA except for call, which stores the return address valP.
  localparam logic DATA_SEL_VALA = 1'b0;
  localparam logic DATA_SEL_VALP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } mai_state_e;

endpackage

// File: rtl/mem_op_decode.sv
// Maps a Y86 icode to the data-memory operation and its operand selects.
// Latency: purely combinational.
// Backpressure: none; output follows icode.
module mem_op_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       is_rd,
  output logic       is_wr,
  output logic       addr_sel,
  output logic       data_sel
);

  // Table lookup; anything not touching memory leaves both strobes low.
  always_comb begin
    is_rd    = 1'b0;
    is_wr    = 1'b0;
    addr_sel = ADDR_SEL_VALE;
    data_sel = DATA_SEL_VALA;
    case (icode)
      IRMMOVQ, IPUSHQ: is_wr = 1'b1;
      IMRMOVQ:         is_rd = 1'b1;
      IRET, IPOPQ: begin
        is_rd    = 1'b1;
        addr_sel = ADDR_SEL_VALA;
      end
      ICALL: begin
        is_wr    = 1'b1;
        data_sel = DATA_SEL_VALP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_initiator.sv
// Memory-stage initiator: decodes the access and runs a req/ack handshake to data memory.
// Latency: no-access done 1 cycle after start; access done in the cycle after the ack edge.
// Backpressure: holds mem_req and operands stable until mem_ack; errors after TIMEOUT waits.
module mem_access_initiator
  import y86_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic        m_module_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int          CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_DEPTH - 1);

  mai_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             we_q, we_d;
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      valm_q, valm_d;

  logic        is_rd, is_wr, addr_sel, data_sel;
  logic [63:0] sel_addr, sel_data;

  mem_op_decode u_decode (
    .icode    (icode),
    .is_rd    (is_rd),
    .is_wr    (is_wr),
    .addr_sel (addr_sel),
    .data_sel (data_sel)
  );

  assign sel_addr = (addr_sel == ADDR_SEL_VALA) ? valA : valE;
  assign sel_data = (data_sel == DATA_SEL_VALP) ? valP : valA;
  assign cnt_inc  = cnt_q + 1'b1;

  // State register; reset drops out of REQ immediately so mem_req falls without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Latched operation, wait counter and read-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valm_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valm_q  <= valm_d;
    end
  end

  // Next-state: range check happens before any request so bad addresses never reach memory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!(is_rd || is_wr))      state_d = ST_DONE;
          else if (sel_addr > ADDR_MAX) state_d = ST_ERR;
          else                        state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack)                          state_d = ST_DONE;
        else if (cnt_inc == CNT_W'(TIMEOUT))  state_d = ST_ERR;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture operands on accept, count waits, take read data on ack.
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valm_d  = valm_q;
    if (state_q == ST_IDLE && start) begin
      cnt_d   = '0;
      we_d    = is_wr;
      addr_d  = sel_addr;
      wdata_d = sel_data;
    end else if (state_q == ST_REQ) begin
      if (mem_ack) begin
        if (!we_q) valm_d = mem_rdata;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Outputs decoded from state; request operands come straight from the latched registers.
  always_comb begin
    busy           = (state_q == ST_REQ) || (state_q == ST_DONE);
    done           = (state_q == ST_DONE);
    mem_req        = (state_q == ST_REQ);
    m_module_error = (state_q == ST_ERR);
    mem_we         = we_q;
    mem_addr       = addr_q;
    mem_wdata      = wdata_q;
    valM           = valm_q;
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
module tb_mem_access_initiator;

  localparam logic [63:0] LAST_ADDR = 64'd255;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic        busy, done, m_module_error, mem_req, mem_we, mem_ack;
  logic [63:0] valM, mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  // Expected outputs for the current cycle, maintained by the stimulus thread.
  logic        run_chk = 1'b0;
  logic        exp_busy = 1'b0, exp_done = 1'b0, exp_req = 1'b0, exp_err = 1'b0, exp_we = 1'b0;
  logic [63:0] exp_addr = '0, exp_wdata = '0, exp_valm = '0;
  // Transaction-level model state.
  logic        m_err = 1'b0;
  logic [63:0] m_valm = '0;
  // Observed request history.
  int          req_cycles = 0;
  logic        last_we = 1'b0;
  logic [63:0] last_addr = '0, last_wdata = '0;

  always #5 clk = ~clk;

  mem_access_initiator #(.MEM_DEPTH(256), .TIMEOUT(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .icode          (icode),
    .valA           (valA),
    .valE           (valE),
    .valP           (valP),
    .busy           (busy),
    .done           (done),
    .valM           (valM),
    .m_module_error (m_module_error),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare every cycle against the model and record what requests looked like.
  always @(negedge clk) begin
    if (run_chk) begin
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      chk("done", {63'd0, done}, {63'd0, exp_done});
      chk("mem_req", {63'd0, mem_req}, {63'd0, exp_req});
      chk("error", {63'd0, m_module_error}, {63'd0, exp_err});
      chk("valM", valM, exp_valm);
      if (exp_req) begin
        chk("mem_we", {63'd0, mem_we}, {63'd0, exp_we});
        chk("mem_addr", mem_addr, exp_addr);
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
    end
    if (mem_req === 1'b1) begin
      req_cycles++;
      last_we    = mem_we;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
    end
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference decode: kind 0 = no access, 1 = read, 2 = write.
  task automatic ref_op(input logic [3:0] ic, input logic [63:0] a, e, p,
                        output int kind, output logic [63:0] ad, output logic [63:0] dt);
    kind = 0; ad = '0; dt = '0;
    case (ic)
      4'h4, 4'hA: begin kind = 2; ad = e; dt = a; end
      4'h8:       begin kind = 2; ad = e; dt = p; end
      4'h5:       begin kind = 1; ad = e; end
      4'h9, 4'hB: begin kind = 1; ad = a; end
      default:    kind = 0;
    endcase
  endtask

  task automatic set_idle();
    exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0;
    exp_err = m_err; exp_valm = m_valm;
  endtask

  // One memory-stage operation. k = ack edge index within REQ (>=1); k <= 0 means never ack.
  task automatic do_op(input logic [3:0] ic, input logic [63:0] a, e, p,
                       input int k, input logic [63:0] rd);
    int kind;
    logic [63:0] ad, dt;
    ref_op(ic, a, e, p, kind, ad, dt);
    start = 1'b1; icode = ic; valA = a; valE = e; valP = p;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = rnd64();
    @(posedge clk); #1;
    start = 1'b0; mem_ack = 1'b0; icode = 4'($urandom_range(0, 15));
    valA = rnd64(); valE = rnd64(); valP = rnd64();
    if (m_err) begin set_idle(); return; end
    if (kind == 0) begin
      exp_busy = 1'b1; exp_done = 1'b1;
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      mem_ack = 1'b0;
      set_idle();
      return;
    end
    if (ad > LAST_ADDR) begin m_err = 1'b1; set_idle(); return; end
    exp_busy = 1'b1; exp_req = 1'b1; exp_we = (kind == 2); exp_addr = ad; exp_wdata = dt;
    if (k <= 0) begin
      for (int i = 1; i <= 15; i++) begin
        mem_ack = 1'b0; mem_rdata = rnd64();
        @(posedge clk); #1;
      end
      m_err = 1'b1;
      set_idle();
      return;
    end
    for (int i = 1; i <= k; i++) begin
      mem_ack = (i == k);
      mem_rdata = (i == k) ? rd : rnd64();
      @(posedge clk); #1;
    end
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = rnd64();
    exp_req = 1'b0; exp_done = 1'b1;
    if (kind == 1) m_valm = rd;
    exp_valm = m_valm;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    set_idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_err = 1'b0; m_valm = '0;
    set_idle();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  int snap;

  initial begin
    reset = 1'b1; start = 1'b0; icode = '0; valA = '0; valE = '0; valP = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, m_module_error}, 64'd0);
    chk("rst_req", {63'd0, mem_req}, 64'd0);
    chk("rst_we", {63'd0, mem_we}, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_valM", valM, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    set_idle();
    run_chk = 1'b1;

    // rmmovq, ack on 2nd REQ cycle.
    do_op(4'h4, 64'hDEAD, 64'h10, 64'h0, 2, 64'h0);
    chk("rmmovq_addr", last_addr, 64'h10);
    chk("rmmovq_data", last_wdata, 64'hDEAD);
    chk("rmmovq_we", {63'd0, last_we}, 64'd1);
    chk("rmmovq_valM", valM, 64'd0);

    // mrmovq, three wait cycles then ack.
    do_op(4'h5, 64'h0, 64'h20, 64'h0, 4, 64'h1234);
    chk("mrmovq_valM", valM, 64'h1234);
    chk("mrmovq_addr", last_addr, 64'h20);

    // call then ret.
    do_op(4'h8, 64'h0, 64'hF8, 64'h40, 1, 64'h0);
    chk("call_addr", last_addr, 64'hF8);
    chk("call_data", last_wdata, 64'h40);
    do_op(4'h9, 64'hF8, 64'h0, 64'h0, 2, 64'h40);
    chk("ret_valM", valM, 64'h40);
    chk("ret_we", {63'd0, last_we}, 64'd0);

    // Highest legal address.
    do_op(4'h5, 64'h0, LAST_ADDR, 64'h0, 1, 64'hCAFE);
    chk("edge_addr_valM", valM, 64'hCAFE);

    // Every icode once, then random traffic.
    for (int ic = 0; ic < 16; ic++)
      do_op(4'(ic), 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), rnd64(),
            1, rnd64());
    for (int n = 0; n < 60; n++)
      do_op(4'($urandom_range(0, 15)), 64'($urandom_range(0, 255)),
            64'($urandom_range(0, 255)), rnd64(), $urandom_range(1, 5), rnd64());

    // Reset in the middle of a request.
    start = 1'b1; icode = 4'h5; valE = 64'h30;
    @(posedge clk); #1;
    start = 1'b0;
    exp_busy = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 64'h30;
    #2;
    reset = 1'b1;
    #1;
    chk("async_req_drop", {63'd0, mem_req}, 64'd0);
    chk("async_busy", {63'd0, busy}, 64'd0);
    chk("async_addr", mem_addr, 64'd0);
    chk("async_valM", valM, 64'd0);
    m_err = 1'b0; m_valm = '0;
    set_idle();
    @(posedge clk); #1;
    reset = 1'b0;
    snap = req_cycles;
    do_op(4'h6, 64'h1, 64'h2, 64'h3, 1, 64'h0);
    chk("opq_no_req", 64'(req_cycles), 64'(snap));

    // Out-of-range popq: error at the start edge, never a request, later starts ignored.
    snap = req_cycles;
    do_op(4'hB, 64'd256, 64'h0, 64'h0, 1, 64'h0);
    chk("oor_err", {63'd0, m_module_error}, 64'd1);
    do_op(4'h6, 64'h0, 64'h0, 64'h0, 1, 64'h0);
    do_op(4'h5, 64'h0, 64'h8, 64'h0, 1, 64'h77);
    chk("oor_no_req", 64'(req_cycles), 64'(snap));
    chk("oor_valM", valM, 64'd0);

    // Timeout, then a late ack that must be ignored.
    do_reset();
    do_op(4'h5, 64'h0, 64'h40, 64'h0, 0, 64'h0);
    chk("timeout_err", {63'd0, m_module_error}, 64'd1);
    snap = req_cycles;
    mem_ack = 1'b1; mem_rdata = 64'h5555;
    repeat (3) @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("late_ack_req", 64'(req_cycles), 64'(snap));
    chk("late_ack_valM", valM, 64'd0);

    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
